// File: rtl/reservation_station_pkg.sv
// Field layout of the 83-bit decomposed instruction and its ctrl sub-fields,
// shared with instruction_decompose.
package reservation_station_pkg;

    localparam int INST_W     = 83;
    localparam int DATA_W     = 32;
    localparam int RD_W       = 5;
    localparam int CTRL_W     = 12;

    localparam int RS2_VT_LSB = 51;
    localparam int S2_V_BIT   = 50;
    localparam int RS1_VT_LSB = 18;
    localparam int S1_V_BIT   = 17;
    localparam int RD_LSB     = 12;
    localparam int CTRL_LSB   = 0;

    localparam int ALUOP_LSB    = 7;
    localparam int ALUOP_W      = 5;
    localparam int MEMWRITE_BIT = 6;
    localparam int MEMREAD_BIT  = 5;
    localparam int MEMTOREG_BIT = 4;
    localparam int BRANCH_BIT   = 3;
    localparam int REGWRITE_BIT = 2;
    localparam int DISP_LSB     = 0;
    localparam int DISP_W       = 2;

    // Packed view matching the offsets above, MSB first.
    typedef struct packed {
        logic [DATA_W-1:0] rs2_vt;
        logic              s2_valid;
        logic [DATA_W-1:0] rs1_vt;
        logic              s1_valid;
        logic [RD_W-1:0]   rd;
        logic [CTRL_W-1:0] ctrl;
    } rs_inst_t;

endpackage

// File: rtl/reservation_station_pick_lowest.sv
// One-hot lowest-set-bit priority picker.
module rs_pick_lowest #(
    parameter int N = 4
) (
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt,
    output logic         any
);

    // Two's complement isolates the lowest set bit.
    assign gnt = req & (~req + N'(1));
    assign any = |req;

endmodule

// File: rtl/reservation_station.sv
// Reservation station: holds instructions until both operands are valid,
// snooping the CDB for producer tags, then issues the lowest ready entry.
module reservation_station
    import reservation_station_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 6
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [INST_W-1:0]            in_inst,
    input  logic                         cdb_valid,
    input  logic [TAG_W-1:0]             cdb_tag,
    input  logic [DATA_W-1:0]            cdb_value,
    output logic                         issue_valid,
    input  logic                         issue_ready,
    output logic [DATA_W-1:0]            issue_rs1_value,
    output logic [DATA_W-1:0]            issue_rs2_value,
    output logic [RD_W-1:0]              issue_rd,
    output logic [CTRL_W-1:0]            issue_ctrl,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

    localparam int OCC_W = $clog2(DEPTH + 1);

    rs_inst_t inst;
    assign inst = rs_inst_t'(in_inst);

    logic [DEPTH-1:0]             busy, v1, v2;
    logic [DEPTH-1:0][DATA_W-1:0] val1, val2;
    logic [DEPTH-1:0][RD_W-1:0]   rd_q;
    logic [DEPTH-1:0][CTRL_W-1:0] ctrl_q;

    logic [DEPTH-1:0] free_oh, rdy_oh;
    logic             free_any, rdy_any;

    rs_pick_lowest #(.N(DEPTH)) u_pick_free (.req(~busy),            .gnt(free_oh), .any(free_any));
    rs_pick_lowest #(.N(DEPTH)) u_pick_rdy  (.req(busy & v1 & v2),   .gnt(rdy_oh),  .any(rdy_any));

    assign in_ready    = free_any & ~flush;
    assign issue_valid = rdy_any & ~flush;

    logic alloc, do_issue, byp1, byp2;
    assign alloc    = in_valid & in_ready;
    assign do_issue = issue_valid & issue_ready;
    // Capture a broadcast that lands in the same cycle as allocation.
    assign byp1 = ~inst.s1_valid & cdb_valid & (cdb_tag == inst.rs1_vt[TAG_W-1:0]);
    assign byp2 = ~inst.s2_valid & cdb_valid & (cdb_tag == inst.rs2_vt[TAG_W-1:0]);

    logic [OCC_W-1:0] occ;
    always_comb begin
        issue_rs1_value = '0;
        issue_rs2_value = '0;
        issue_rd        = '0;
        issue_ctrl      = '0;
        occ             = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rdy_oh[i]) begin
                issue_rs1_value = issue_rs1_value | val1[i];
                issue_rs2_value = issue_rs2_value | val2[i];
                issue_rd        = issue_rd | rd_q[i];
                issue_ctrl      = issue_ctrl | ctrl_q[i];
            end
            occ = occ + OCC_W'(busy[i]);
        end
    end
    assign occupancy = occ;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy   <= '0;
            v1     <= '0;
            v2     <= '0;
            val1   <= '0;
            val2   <= '0;
            rd_q   <= '0;
            ctrl_q <= '0;
        end else if (flush) begin
            busy <= '0;
            v1   <= '0;
            v2   <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (alloc && free_oh[i]) begin
                    busy[i]   <= 1'b1;
                    v1[i]     <= inst.s1_valid | byp1;
                    v2[i]     <= inst.s2_valid | byp2;
                    val1[i]   <= byp1 ? cdb_value : inst.rs1_vt;
                    val2[i]   <= byp2 ? cdb_value : inst.rs2_vt;
                    rd_q[i]   <= inst.rd;
                    ctrl_q[i] <= inst.ctrl;
                end else begin
                    if (do_issue && rdy_oh[i])
                        busy[i] <= 1'b0;
                    if (busy[i] && !v1[i] && cdb_valid && cdb_tag == val1[i][TAG_W-1:0]) begin
                        v1[i]   <= 1'b1;
                        val1[i] <= cdb_value;
                    end
                    if (busy[i] && !v2[i] && cdb_valid && cdb_tag == val2[i][TAG_W-1:0]) begin
                        v2[i]   <= 1'b1;
                        val2[i] <= cdb_value;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_reservation_station.sv
// Bench for reservation_station: vector table through a scoreboard, plus
// hand sequences for wakeup latency, back-pressure, flush and async reset.
module tb_reservation_station;

    logic        clk, rst_n, flush, in_valid, in_ready;
    logic [82:0] in_inst;
    logic        cdb_valid;
    logic [5:0]  cdb_tag;
    logic [31:0] cdb_value;
    logic        issue_valid, issue_ready;
    logic [31:0] issue_rs1_value, issue_rs2_value;
    logic [4:0]  issue_rd;
    logic [11:0] issue_ctrl;
    logic [2:0]  occupancy;

    reservation_station #(.DEPTH(4), .TAG_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_rs1_value(issue_rs1_value), .issue_rs2_value(issue_rs2_value),
        .issue_rd(issue_rd), .issue_ctrl(issue_ctrl), .occupancy(occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic s1v; logic [31:0] rs1; logic s2v; logic [31:0] rs2;
        logic [4:0] rd; logic [11:0] ctrl;
        logic byp;  logic [5:0] byp_tag;  logic [31:0] byp_val;
        logic wake; logic [5:0] wake_tag; logic [31:0] wake_val;
        logic [31:0] e1; logic [31:0] e2;
    } vec_t;

    typedef struct {
        logic [31:0] rs1; logic [31:0] rs2; logic [4:0] rd; logic [11:0] ctrl;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[6];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [82:0] mk(input logic s1v, input logic [31:0] rs1,
                                       input logic s2v, input logic [31:0] rs2,
                                       input logic [4:0] rd, input logic [11:0] ctrl);
        return {rs2, s2v, rs1, s1v, rd, ctrl};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] rs1, input logic [31:0] rs2,
                        input logic [4:0] rd, input logic [11:0] ctrl);
        exp_t e;
        e.rs1 = rs1; e.rs2 = rs2; e.rd = rd; e.ctrl = ctrl;
        sb.push_back(e);
    endtask

    task automatic drain(input string name);
        for (int k = 0; k < 12 && sb.size() != 0; k++) cyc();
        chk(name, sb.size(), 0);
    endtask

    // Scoreboard monitor: compares every accepted issue against the queue head.
    always @(negedge clk) begin
        if (rst_n && issue_valid && issue_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_issue: got rs1=%h with nothing expected", issue_rs1_value);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("issue_rs1", issue_rs1_value, e.rs1);
                chk("issue_rs2", issue_rs2_value, e.rs2);
                chk("issue_rd", {27'd0, issue_rd}, {27'd0, e.rd});
                chk("issue_ctrl", {20'd0, issue_ctrl}, {20'd0, e.ctrl});
            end
        end
    end

    initial begin
        vecs[0] = '{1'b1, 32'h5, 1'b1, 32'h7, 5'd3, 12'h0A5,
                    1'b0, 6'h00, 32'h0, 1'b0, 6'h00, 32'h0, 32'h5, 32'h7};
        vecs[1] = '{1'b0, 32'hABCD0012, 1'b1, 32'h0000BEEF, 5'd4, 12'hF01,
                    1'b0, 6'h00, 32'h0, 1'b1, 6'h12, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0000BEEF};
        vecs[2] = '{1'b1, 32'h11112222, 1'b0, 32'h0000002A, 5'd31, 12'h7FF,
                    1'b1, 6'h2A, 32'h00001234, 1'b0, 6'h00, 32'h0, 32'h11112222, 32'h00001234};
        vecs[3] = '{1'b0, 32'h000000C5, 1'b0, 32'h00000045, 5'd0, 12'h800,
                    1'b1, 6'h05, 32'h0000CAFE, 1'b0, 6'h00, 32'h0, 32'h0000CAFE, 32'h0000CAFE};
        vecs[4] = '{1'b1, 32'h00000012, 1'b0, 32'h1234567F, 5'd17, 12'h123,
                    1'b1, 6'h12, 32'h0000FFFF, 1'b1, 6'h3F, 32'hA5A5A5A5, 32'h00000012, 32'hA5A5A5A5};
        vecs[5] = '{1'b0, 32'h00000001, 1'b0, 32'h00000002, 5'd9, 12'h456,
                    1'b1, 6'h01, 32'h00000011, 1'b1, 6'h02, 32'h00000022, 32'h00000011, 32'h00000022};

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_inst = '0;
        cdb_valid = 1'b0; cdb_tag = '0; cdb_value = '0; issue_ready = 1'b0;

        // Reset state
        #8;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_issue_valid", issue_valid, 0);
        chk("rst_occupancy", occupancy, 0);
        chk("rst_issue_rs1", issue_rs1_value, 0);
        #4 rst_n = 1'b1;
        cyc();

        // Table-driven vectors: ready, wakeup, bypass and mixed cases
        for (int v = 0; v < 6; v++) begin
            issue_ready = 1'b1;
            in_valid    = 1'b1;
            in_inst     = mk(vecs[v].s1v, vecs[v].rs1, vecs[v].s2v, vecs[v].rs2, vecs[v].rd, vecs[v].ctrl);
            cdb_valid   = vecs[v].byp;
            cdb_tag     = vecs[v].byp_tag;
            cdb_value   = vecs[v].byp_val;
            push(vecs[v].e1, vecs[v].e2, vecs[v].rd, vecs[v].ctrl);
            cyc();
            in_valid  = 1'b0;
            cdb_valid = vecs[v].wake;
            cdb_tag   = vecs[v].wake_tag;
            cdb_value = vecs[v].wake_val;
            cyc();
            cdb_valid = 1'b0;
            drain("vec_drain");
            @(negedge clk);
            chk("vec_occupancy", occupancy, 0);
            cyc();
        end

        // Wakeup latency and wrong-tag rejection
        issue_ready = 1'b0;
        in_valid    = 1'b1;
        in_inst     = mk(1'b0, 32'h12, 1'b1, 32'h9, 5'd7, 12'h3C3);
        cyc();
        in_valid = 1'b0; cdb_valid = 1'b1; cdb_tag = 6'h13; cdb_value = 32'h1;
        cyc();
        cdb_valid = 1'b0;
        @(negedge clk);
        chk("wrong_tag_issue_valid", issue_valid, 0);
        chk("wrong_tag_occupancy", occupancy, 1);
        cyc();
        cdb_valid = 1'b1; cdb_tag = 6'h12; cdb_value = 32'hDEADBEEF;
        @(negedge clk);
        chk("wake_same_cycle_valid", issue_valid, 0);
        cyc();
        cdb_valid = 1'b0;
        @(negedge clk);
        chk("wake_next_cycle_valid", issue_valid, 1);
        chk("wake_rs1", issue_rs1_value, 32'hDEADBEEF);
        cyc();
        push(32'hDEADBEEF, 32'h9, 5'd7, 12'h3C3);
        issue_ready = 1'b1;
        drain("wake_drain");
        @(negedge clk);
        chk("wake_occupancy", occupancy, 0);
        cyc();

        // Fill, out-of-order wakeup, back-pressure, then issue+insert together
        issue_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            in_valid = 1'b1;
            in_inst  = mk(1'b0, 32'(k), 1'b1, 32'h1000 + 32'(k), 5'(k), 12'(k));
            cyc();
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("full_occupancy", occupancy, 4);
        chk("full_in_ready", in_ready, 0);
        cyc();
        cdb_valid = 1'b1; cdb_tag = 6'd3; cdb_value = 32'h300;
        cyc();
        cdb_tag = 6'd1; cdb_value = 32'h100;
        @(negedge clk);
        chk("sel_only_entry2", issue_rs1_value, 32'h300);
        cyc();
        cdb_tag = 6'd2; cdb_value = 32'h200;
        @(negedge clk);
        chk("sel_lowest_entry0", issue_rs1_value, 32'h100);
        cyc();
        cdb_tag = 6'd4; cdb_value = 32'h400;
        cyc();
        cdb_valid = 1'b0;
        cyc();
        @(negedge clk);
        chk("hold_issue_valid", issue_valid, 1);
        chk("hold_rs1", issue_rs1_value, 32'h100);
        chk("hold_occupancy", occupancy, 4);
        cyc();
        push(32'h100, 32'h1001, 5'd1, 12'd1);
        push(32'h200, 32'h1002, 5'd2, 12'd2);
        push(32'hEE,  32'hEF,   5'd9, 12'h999);
        push(32'h300, 32'h1003, 5'd3, 12'd3);
        push(32'h400, 32'h1004, 5'd4, 12'd4);
        issue_ready = 1'b1;
        cyc();
        in_valid = 1'b1;
        in_inst  = mk(1'b1, 32'hEE, 1'b1, 32'hEF, 5'd9, 12'h999);
        @(negedge clk);
        chk("after_issue_occupancy", occupancy, 3);
        chk("after_issue_in_ready", in_ready, 1);
        cyc();
        in_valid    = 1'b0;
        issue_ready = 1'b0;
        @(negedge clk);
        chk("issue_insert_occupancy", occupancy, 3);
        chk("realloc_lowest_free", issue_rs1_value, 32'hEE);
        cyc();
        issue_ready = 1'b1;
        drain("full_drain");
        @(negedge clk);
        chk("full_drain_occupancy", occupancy, 0);
        cyc();

        // Flush with concurrent insert, CDB and issue attempt
        issue_ready = 1'b0;
        in_valid = 1'b1; in_inst = mk(1'b0, 32'h7, 1'b1, 32'h1, 5'd1, 12'h1); cyc();
        in_inst = mk(1'b0, 32'h8, 1'b1, 32'h2, 5'd2, 12'h2); cyc();
        in_inst = mk(1'b1, 32'h55, 1'b1, 32'h66, 5'd3, 12'h3); cyc();
        flush = 1'b1; issue_ready = 1'b1;
        in_inst = mk(1'b1, 32'h1, 1'b1, 32'h2, 5'd4, 12'h4);
        cdb_valid = 1'b1; cdb_tag = 6'h07; cdb_value = 32'h77;
        @(negedge clk);
        chk("flush_in_ready", in_ready, 0);
        chk("flush_issue_valid", issue_valid, 0);
        cyc();
        flush = 1'b0; in_valid = 1'b0;
        cdb_tag = 6'h08; cdb_value = 32'h88;
        @(negedge clk);
        chk("post_flush_occupancy", occupancy, 0);
        chk("post_flush_issue_valid", issue_valid, 0);
        cyc();
        cdb_valid = 1'b0;
        @(negedge clk);
        chk("post_flush_stale_cdb", issue_valid, 0);
        cyc();

        // Async reset mid-traffic with ready entries waiting
        issue_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_inst  = mk(1'b1, 32'hA0 + 32'(k), 1'b1, 32'hB0, 5'd5, 12'h5);
            cyc();
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("pre_reset_occupancy", occupancy, 3);
        cyc();
        rst_n = 1'b0;
        #1;
        chk("async_rst_in_ready", in_ready, 1);
        chk("async_rst_issue_valid", issue_valid, 0);
        chk("async_rst_occupancy", occupancy, 0);
        #2 rst_n = 1'b1;
        cyc();
        cyc();
        chk("final_scoreboard_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
